segscan_decoder: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Samples the active-low seg/an scan lines and identifies the lit digit position. Decodes each glyph to a 4-bit symbol code and reassembles complete 4-digit frames.
- Used as an on-chip loopback checker and as the observation point for the countdown display in simulation and hardware self-test.

---
 rtl/segscan_pkg.sv | 44 ++++
 rtl/segscan_if.sv | 25 ++
 rtl/segscan_glyph_decode.sv | 25 ++
 rtl/segscan_decoder.sv | 146 ++++++++++++++
 tb/tb_segscan_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/segscan_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph patterns,
// symbol codes, anode positions and the frame-assembly FSM states.
package segscan_pkg;

   // Active-low glyph patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_ONE   = 7'b1111001;
   localparam logic [6:0] GLYPH_TWO   = 7'b0100100;
   localparam logic [6:0] GLYPH_THREE = 7'b0110000;
   localparam logic [6:0] GLYPH_G     = 7'b1000010;
   localparam logic [6:0] GLYPH_O     = 7'b1000000;

   localparam logic [3:0] SYM_BLANK = 4'h0;
   localparam logic [3:0] SYM_ONE   = 4'h1;
   localparam logic [3:0] SYM_TWO   = 4'h2;
   localparam logic [3:0] SYM_THREE = 4'h3;
   localparam logic [3:0] SYM_G     = 4'h4;
   localparam logic [3:0] SYM_O     = 4'h5;
   localparam logic [3:0] SYM_UNK   = 4'hF;

   localparam logic [3:0] AN_POS3 = 4'b0111;
   localparam logic [3:0] AN_POS2 = 4'b1011;
   localparam logic [3:0] AN_POS1 = 4'b1101;
   localparam logic [3:0] AN_POS0 = 4'b1110;
   localparam logic [3:0] AN_IDLE = 4'b1111;

   typedef enum logic [2:0] {SYNC, EXP3, EXP2, EXP1, EXP0} state_t;

   typedef enum logic [2:0] {POS0, POS1, POS2, POS3, POS_IDLE, POS_ILLEGAL} pos_t;

   function automatic pos_t decode_anode(input logic [3:0] an);
      pos_t p;
      case (an)
         AN_POS3: p = POS3;
         AN_POS2: p = POS2;
         AN_POS1: p = POS1;
         AN_POS0: p = POS0;
         AN_IDLE: p = POS_IDLE;
         default: p = POS_ILLEGAL;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/segscan_if.sv
// Scan-line and result bundle between a display-scan source and the decoder.
interface segscan_if;
   import segscan_pkg::*;

   logic        en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        err_clear;
   logic [15:0] frame;
   logic        frame_valid;
   logic        frame_stable;
   logic        err_order;
   logic        err_glyph;

   modport master (
      output en, seg, an, err_clear,
      input  frame, frame_valid, frame_stable, err_order, err_glyph
   );

   modport slave (
      input  en, seg, an, err_clear,
      output frame, frame_valid, frame_stable, err_order, err_glyph
   );

endinterface

// File: rtl/segscan_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern to symbol code,
// flagging any pattern outside the known glyph set.
module seg_glyph_decode
   import segscan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] sym,
   output logic       unknown
);

   always_comb begin
      sym     = SYM_UNK;
      unknown = 1'b0;
      case (seg)
         GLYPH_BLANK: sym = SYM_BLANK;
         GLYPH_ONE:   sym = SYM_ONE;
         GLYPH_TWO:   sym = SYM_TWO;
         GLYPH_THREE: sym = SYM_THREE;
         GLYPH_G:     sym = SYM_G;
         GLYPH_O:     sym = SYM_O;
         default:     unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/segscan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment scan: tracks
// the anode sequence, reassembles frames and reports stability and errors.
module segscan_decoder
   import segscan_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES = 2
) (
   input logic      segclk,
   input logic      rst,
   segscan_if.slave bus
);

   localparam logic [3:0] STABLE_THR = 4'(STABLE_FRAMES);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'h1;
   endfunction

   function automatic pos_t expected_pos(input state_t s);
      pos_t p;
      case (s)
         EXP3:    p = POS3;
         EXP2:    p = POS2;
         EXP1:    p = POS1;
         EXP0:    p = POS0;
         default: p = POS_ILLEGAL;
      endcase
      return p;
   endfunction

   pos_t        pos;
   logic [3:0]  sym;
   logic        unk;

   state_t      state_q, state_d;
   logic [3:0]  d3_q, d2_q, d1_q;
   logic [15:0] frame_q;
   logic        frame_valid_q;
   logic [3:0]  count_q, count_d;
   logic        stable_q;
   logic        err_order_q, err_glyph_q;

   logic        cap3, cap2, cap1, cap0;
   logic        order_err, glyph_err, to_sync;
   logic [15:0] new_frame;

   assign pos = decode_anode(bus.an);

   seg_glyph_decode u_glyph (
      .seg     (bus.seg),
      .sym     (sym),
      .unknown (unk)
   );

   // Next-state and capture strobes; nothing advances while en is low
   always_comb begin
      state_d   = state_q;
      cap3      = 1'b0;
      cap2      = 1'b0;
      cap1      = 1'b0;
      cap0      = 1'b0;
      order_err = 1'b0;
      to_sync   = 1'b0;
      if (bus.en) begin
         if (state_q == SYNC) begin
            if (pos == POS3) begin
               cap3    = 1'b1;
               state_d = EXP2;
            end else if (pos == POS_ILLEGAL) begin
               order_err = 1'b1;
            end
         end else if (pos == POS_ILLEGAL) begin
            order_err = 1'b1;
            state_d   = SYNC;
            to_sync   = 1'b1;
         end else if (pos == POS_IDLE) begin
            state_d = SYNC;
            to_sync = 1'b1;
         end else if (pos == expected_pos(state_q)) begin
            case (state_q)
               EXP3:    begin cap3 = 1'b1; state_d = EXP2; end
               EXP2:    begin cap2 = 1'b1; state_d = EXP1; end
               EXP1:    begin cap1 = 1'b1; state_d = EXP0; end
               EXP0:    begin cap0 = 1'b1; state_d = EXP3; end
               default: state_d = SYNC;
            endcase
         end else begin
            // A stray pos3 is still a clean frame start, so resync onto it
            order_err = 1'b1;
            if (pos == POS3) begin
               cap3    = 1'b1;
               state_d = EXP2;
            end else begin
               state_d = SYNC;
               to_sync = 1'b1;
            end
         end
      end
   end

   assign glyph_err = unk & (cap3 | cap2 | cap1 | cap0);
   assign new_frame = {d3_q, d2_q, d1_q, sym};

   always_comb begin
      count_d = count_q;
      if (cap0) begin
         count_d = (new_frame == frame_q) ? sat_inc(count_q) : 4'h1;
      end else if (to_sync) begin
         count_d = 4'h0;
      end
   end

   // Register stage: state, partial digits, completed frame and status
   always_ff @(posedge segclk) begin
      if (rst) begin
         state_q       <= SYNC;
         d3_q          <= 4'h0;
         d2_q          <= 4'h0;
         d1_q          <= 4'h0;
         frame_q       <= 16'h0000;
         frame_valid_q <= 1'b0;
         count_q       <= 4'h0;
         stable_q      <= 1'b0;
         err_order_q   <= 1'b0;
         err_glyph_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_valid_q <= cap0;
         if (cap3) d3_q <= sym;
         if (cap2) d2_q <= sym;
         if (cap1) d1_q <= sym;
         if (cap0) frame_q <= new_frame;
         count_q     <= count_d;
         stable_q    <= (count_d >= STABLE_THR);
         err_order_q <= order_err | (err_order_q & ~bus.err_clear);
         err_glyph_q <= glyph_err | (err_glyph_q & ~bus.err_clear);
      end
   end

   assign bus.frame        = frame_q;
   assign bus.frame_valid  = frame_valid_q;
   assign bus.frame_stable = stable_q;
   assign bus.err_order    = err_order_q;
   assign bus.err_glyph    = err_glyph_q;

endmodule

// File: tb/tb_segscan_decoder.sv
// Directed testbench for segscan_decoder: scans countdown glyph frames and
// scan-order faults through the interface and checks hand-computed results.
module tb_segscan_decoder;
   import segscan_pkg::*;

   logic segclk;
   logic rst;
   int   checks;
   int   errors;

   segscan_if bus ();

   segscan_decoder #(.STABLE_FRAMES(2)) dut (
      .segclk (segclk),
      .rst    (rst),
      .bus    (bus)
   );

   initial begin
      segclk = 1'b0;
      forever #5 segclk = ~segclk;
   end

   task automatic drive(input logic [6:0] s, input logic [3:0] a);
      bus.seg = s;
      bus.an  = a;
      @(posedge segclk);
      #1;
   endtask

   // Full scan pos3..pos0; n counts frame_valid samples seen after each edge
   task automatic scan(input logic [6:0] g3, input logic [6:0] g2,
                       input logic [6:0] g1, input logic [6:0] g0, output int n);
      n = 0;
      drive(g3, AN_POS3); n += int'(bus.frame_valid);
      drive(g2, AN_POS2); n += int'(bus.frame_valid);
      drive(g1, AN_POS1); n += int'(bus.frame_valid);
      drive(g0, AN_POS0); n += int'(bus.frame_valid);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge segclk);
      #1;
      checks++; if (bus.frame !== 16'h0000) begin errors++; $display("FAIL reset_frame got %h want 0000", bus.frame); end
      checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.frame_valid); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL reset_stable got %b want 0", bus.frame_stable); end
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL reset_err_order got %b want 0", bus.err_order); end
      checks++; if (bus.err_glyph !== 1'b0) begin errors++; $display("FAIL reset_err_glyph got %b want 0", bus.err_glyph); end
      rst = 1'b0;
   endtask

   task automatic test_value0;
      int n;
      drive(GLYPH_BLANK, AN_POS3);
      drive(GLYPH_BLANK, AN_POS2);
      drive(GLYPH_THREE, AN_POS1);
      checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL v0_early_valid got %b want 0", bus.frame_valid); end
      drive(GLYPH_BLANK, AN_POS0);
      checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL v0_valid got %b want 1", bus.frame_valid); end
      checks++; if (bus.frame !== 16'h0030) begin errors++; $display("FAIL v0_frame got %h want 0030", bus.frame); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL v0_stable1 got %b want 0", bus.frame_stable); end
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_THREE, GLYPH_BLANK, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL v0_pulses got %0d want 1", n); end
      checks++; if (bus.frame_stable !== 1'b1) begin errors++; $display("FAIL v0_stable2 got %b want 1", bus.frame_stable); end
   endtask

   task automatic test_value3;
      int n, total;
      total = 0;
      scan(GLYPH_BLANK, GLYPH_G, GLYPH_O, GLYPH_BLANK, n);
      total += n;
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL v3_stable1 got %b want 0", bus.frame_stable); end
      for (int f = 0; f < 2; f++) begin
         scan(GLYPH_BLANK, GLYPH_G, GLYPH_O, GLYPH_BLANK, n);
         total += n;
         checks++; if (bus.frame_stable !== 1'b1) begin errors++; $display("FAIL v3_stable_f%0d got %b want 1", f + 2, bus.frame_stable); end
      end
      checks++; if (total !== 3) begin errors++; $display("FAIL v3_pulses got %0d want 3", total); end
      checks++; if (bus.frame !== 16'h0450) begin errors++; $display("FAIL v3_frame got %h want 0450", bus.frame); end
      checks++; if ({bus.err_order, bus.err_glyph} !== 2'b00) begin errors++; $display("FAIL v3_errors got %b want 00", {bus.err_order, bus.err_glyph}); end
   endtask

   task automatic test_switch;
      int n;
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_TWO, GLYPH_BLANK, n);
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_TWO, GLYPH_BLANK, n);
      checks++; if (bus.frame_stable !== 1'b1) begin errors++; $display("FAIL sw_stable_v1 got %b want 1", bus.frame_stable); end
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_ONE, GLYPH_BLANK, n);
      checks++; if (bus.frame !== 16'h0010) begin errors++; $display("FAIL sw_frame got %h want 0010", bus.frame); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL sw_stable_drop got %b want 0", bus.frame_stable); end
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_ONE, GLYPH_BLANK, n);
      checks++; if (bus.frame_stable !== 1'b1) begin errors++; $display("FAIL sw_stable_back got %b want 1", bus.frame_stable); end
   endtask

   task automatic test_order;
      drive(GLYPH_BLANK, AN_POS3);
      drive(GLYPH_BLANK, AN_POS1);
      checks++; if (bus.err_order !== 1'b1) begin errors++; $display("FAIL ord_skip got %b want 1", bus.err_order); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL ord_stable got %b want 0", bus.frame_stable); end
      drive(GLYPH_BLANK, AN_POS0);
      checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL ord_no_valid got %b want 0", bus.frame_valid); end
      bus.err_clear = 1'b1;
      drive(GLYPH_BLANK, AN_IDLE);
      bus.err_clear = 1'b0;
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL ord_clear got %b want 0", bus.err_order); end
      drive(GLYPH_BLANK, 4'b0011);
      checks++; if (bus.err_order !== 1'b1) begin errors++; $display("FAIL ord_illegal got %b want 1", bus.err_order); end
      bus.err_clear = 1'b1;
      drive(GLYPH_BLANK, 4'b0000);
      checks++; if (bus.err_order !== 1'b1) begin errors++; $display("FAIL ord_set_wins got %b want 1", bus.err_order); end
      drive(GLYPH_BLANK, AN_IDLE);
      bus.err_clear = 1'b0;
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL ord_clear2 got %b want 0", bus.err_order); end
      checks++; if (bus.frame !== 16'h0010) begin errors++; $display("FAIL ord_frame_held got %h want 0010", bus.frame); end
   endtask

   task automatic test_glyph;
      int n;
      scan(GLYPH_BLANK, GLYPH_BLANK, 7'b0000000, GLYPH_BLANK, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL gl_pulses got %0d want 1", n); end
      checks++; if (bus.frame !== 16'h00F0) begin errors++; $display("FAIL gl_frame got %h want 00F0", bus.frame); end
      checks++; if (bus.err_glyph !== 1'b1) begin errors++; $display("FAIL gl_err got %b want 1", bus.err_glyph); end
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL gl_err_order got %b want 0", bus.err_order); end
      bus.err_clear = 1'b1;
      drive(GLYPH_BLANK, AN_IDLE);
      bus.err_clear = 1'b0;
      checks++; if (bus.err_glyph !== 1'b0) begin errors++; $display("FAIL gl_clear got %b want 0", bus.err_glyph); end
   endtask

   task automatic test_enable;
      drive(GLYPH_G, AN_POS3);
      drive(GLYPH_O, AN_POS2);
      bus.en = 1'b0;
      drive(GLYPH_THREE, AN_POS0);
      drive(7'b0000000, 4'b0000);
      checks++; if ({bus.err_order, bus.err_glyph} !== 2'b00) begin errors++; $display("FAIL en_ignored got %b want 00", {bus.err_order, bus.err_glyph}); end
      bus.en = 1'b1;
      drive(GLYPH_ONE, AN_POS1);
      drive(GLYPH_TWO, AN_POS0);
      checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL en_valid got %b want 1", bus.frame_valid); end
      checks++; if (bus.frame !== 16'h4512) begin errors++; $display("FAIL en_frame got %h want 4512", bus.frame); end
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL en_err_order got %b want 0", bus.err_order); end
   endtask

   task automatic test_partial;
      int n;
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_THREE, GLYPH_BLANK, n);
      scan(GLYPH_BLANK, GLYPH_BLANK, GLYPH_THREE, GLYPH_BLANK, n);
      checks++; if (bus.frame_stable !== 1'b1) begin errors++; $display("FAIL pt_stable_pre got %b want 1", bus.frame_stable); end
      drive(GLYPH_BLANK, AN_POS3);
      drive(GLYPH_BLANK, AN_POS2);
      drive(GLYPH_BLANK, AN_IDLE);
      checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL pt_idle_valid got %b want 0", bus.frame_valid); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL pt_idle_stable got %b want 0", bus.frame_stable); end
      checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL pt_idle_err got %b want 0", bus.err_order); end
      checks++; if (bus.frame !== 16'h0030) begin errors++; $display("FAIL pt_frame_held got %h want 0030", bus.frame); end
      drive(GLYPH_BLANK, 4'b0000);
      drive(GLYPH_BLANK, AN_POS3);
      drive(GLYPH_BLANK, AN_POS2);
      rst = 1'b1;
      drive(GLYPH_BLANK, AN_POS1);
      rst = 1'b0;
      checks++; if (bus.frame !== 16'h0000) begin errors++; $display("FAIL pt_rst_frame got %h want 0000", bus.frame); end
      checks++; if ({bus.frame_valid, bus.frame_stable, bus.err_order, bus.err_glyph} !== 4'b0000) begin
         errors++; $display("FAIL pt_rst_flags got %b want 0000", {bus.frame_valid, bus.frame_stable, bus.err_order, bus.err_glyph});
      end
      scan(GLYPH_BLANK, GLYPH_G, GLYPH_O, GLYPH_BLANK, n);
      checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL pt_after_valid got %b want 1", bus.frame_valid); end
      checks++; if (bus.frame !== 16'h0450) begin errors++; $display("FAIL pt_after_frame got %h want 0450", bus.frame); end
      checks++; if (bus.frame_stable !== 1'b0) begin errors++; $display("FAIL pt_after_stable got %b want 0", bus.frame_stable); end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.en        = 1'b1;
      bus.seg       = GLYPH_BLANK;
      bus.an        = AN_IDLE;
      bus.err_clear = 1'b0;
      test_reset();
      test_value0();
      test_value3();
      test_switch();
      test_order();
      test_glyph();
      test_enable();
      test_partial();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
